// File: rtl/mesh_task_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_task_sched_if
//  Brief    : Host/mesh-facing bundle of the task scheduler (control + PE buses)
//  Revision : 1.0 - initial release
// ============================================================================
interface mesh_task_sched_if #(
    parameter int NUM_PE = 8,
    parameter int CNT_W  = 16
) ();
    logic                  cfg_wr;
    logic [2:0]            cfg_pe;
    logic [38:0]           cfg_data;
    logic                  start;
    logic [NUM_PE-1:0]     pe_mask;
    logic                  abort;
    logic [CNT_W-1:0]      timeout_limit;
    logic [NUM_PE-1:0]     pe_task_send_finish_flag;
    logic [NUM_PE-1:0]     pe_task_receive_finish_flag;

    logic [NUM_PE-1:0]     pe_enable;
    logic [NUM_PE-1:0]     pe_flush;
    logic [NUM_PE-1:0]     pe_dbg_mode_wire;
    logic [NUM_PE*3-1:0]   pe_send_num_wire;
    logic [NUM_PE*3-1:0]   pe_receive_num_wire;
    logic [NUM_PE*4-1:0]   pe_rate_wire;
    logic [NUM_PE*4-1:0]   pe_mode_wire;
    logic [NUM_PE*24-1:0]  pe_dst_seq_wire;
    logic                  busy;
    logic                  done;
    logic [1:0]            status;
    logic [CNT_W-1:0]      cycle_cnt;

    modport slave (
        input  cfg_wr, cfg_pe, cfg_data, start, pe_mask, abort, timeout_limit,
               pe_task_send_finish_flag, pe_task_receive_finish_flag,
        output pe_enable, pe_flush, pe_dbg_mode_wire, pe_send_num_wire,
               pe_receive_num_wire, pe_rate_wire, pe_mode_wire, pe_dst_seq_wire,
               busy, done, status, cycle_cnt
    );

    modport master (
        output cfg_wr, cfg_pe, cfg_data, start, pe_mask, abort, timeout_limit,
               pe_task_send_finish_flag, pe_task_receive_finish_flag,
        input  pe_enable, pe_flush, pe_dbg_mode_wire, pe_send_num_wire,
               pe_receive_num_wire, pe_rate_wire, pe_mode_wire, pe_dst_seq_wire,
               busy, done, status, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mesh_task_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_task_sched
//  Brief    : Shadow PE config + FLUSH/RUN/DONE run sequencer for the 2x4 mesh.
//             Optional macro TASK_TIMEOUT_EN enables the RUN-cycle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module mesh_task_sched #(
    parameter int NUM_PE       = 8,
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mesh_task_sched_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int             FC_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] C_FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    logic [1:0]           r_state, w_state_n;
    logic [1:0]           r_status, w_status_n;
    logic [FC_W-1:0]      r_fcnt;
    logic [NUM_PE-1:0]    r_mask, w_mask_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_inc;
    logic                 r_first;
    logic [NUM_PE-1:0]    r_enable, r_flush, r_dbg;
    logic                 r_busy, r_done;
    logic [NUM_PE*24-1:0] r_dst_seq;
    logic [NUM_PE*4-1:0]  r_rate, r_mode;
    logic [NUM_PE*3-1:0]  r_rnum, r_snum;
    logic                 w_start_ok, w_complete, w_timeout;

    assign w_start_ok = (r_state == S_IDLE) && bus.start;
    assign w_mask_n   = w_start_ok ? bus.pe_mask : r_mask;
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    // Flags seen in the first RUN cycle may still be left over from a previous run.
    assign w_complete = !r_first &&
        (((bus.pe_task_send_finish_flag & bus.pe_task_receive_finish_flag) | ~r_mask)
         == {NUM_PE{1'b1}});

`ifdef TASK_TIMEOUT_EN
    logic [CNT_W-1:0] r_limit;
    assign w_timeout = (r_limit != '0) && (r_cnt == r_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_limit <= '0;
        else if (w_start_ok) r_limit <= bus.timeout_limit;
    end
`else
    logic w_unused_limit;
    assign w_unused_limit = ^bus.timeout_limit;
    assign w_timeout      = 1'b0;
`endif

    always_comb begin
        w_state_n  = r_state;
        w_status_n = r_status;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_n  = S_FLUSH;
                    w_status_n = 2'b00;
                end
            end
            S_FLUSH: begin
                if (bus.abort) begin
                    w_state_n  = S_DONE;
                    w_status_n = 2'b10;
                end else if (r_fcnt == C_FLUSH_LAST) begin
                    w_state_n  = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_n  = S_DONE;
                    w_status_n = 2'b10;
                end else if (w_complete) begin
                    w_state_n  = S_DONE;
                    w_status_n = 2'b00;
                end else if (w_timeout) begin
                    w_state_n  = S_DONE;
                    w_status_n = 2'b01;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_status  <= 2'b00;
            r_fcnt    <= '0;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b1;
            r_enable  <= '0;
            r_flush   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dst_seq <= '0;
            r_rate    <= '0;
            r_mode    <= '0;
            r_rnum    <= '0;
            r_snum    <= '0;
            r_dbg     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_status <= w_status_n;
            r_fcnt   <= (r_state == S_FLUSH) ? r_fcnt + 1'b1 : '0;
            r_first  <= (r_state != S_RUN);
            r_mask   <= w_mask_n;
            if (w_start_ok)
                r_cnt <= '0;
            else if (w_state_n == S_RUN)
                r_cnt <= w_cnt_inc;
            r_enable <= (w_state_n == S_RUN)   ? w_mask_n : '0;
            r_flush  <= (w_state_n == S_FLUSH) ? w_mask_n : '0;
            r_busy   <= (w_state_n == S_FLUSH) || (w_state_n == S_RUN);
            r_done   <= (w_state_n == S_DONE);
            if ((r_state == S_IDLE) && bus.cfg_wr) begin
                r_dst_seq[32'(bus.cfg_pe) * 24 +: 24] <= bus.cfg_data[38:15];
                r_rate[32'(bus.cfg_pe) * 4 +: 4]      <= bus.cfg_data[14:11];
                r_mode[32'(bus.cfg_pe) * 4 +: 4]      <= bus.cfg_data[10:7];
                r_rnum[32'(bus.cfg_pe) * 3 +: 3]      <= bus.cfg_data[6:4];
                r_snum[32'(bus.cfg_pe) * 3 +: 3]      <= bus.cfg_data[3:1];
                r_dbg[bus.cfg_pe]                     <= bus.cfg_data[0];
            end
        end
    end

    assign bus.pe_enable           = r_enable;
    assign bus.pe_flush            = r_flush;
    assign bus.pe_dbg_mode_wire    = r_dbg;
    assign bus.pe_send_num_wire    = r_snum;
    assign bus.pe_receive_num_wire = r_rnum;
    assign bus.pe_rate_wire        = r_rate;
    assign bus.pe_mode_wire        = r_mode;
    assign bus.pe_dst_seq_wire     = r_dst_seq;
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.status              = r_status;
    assign bus.cycle_cnt           = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_mesh_task_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mesh_task_sched
//  Brief    : Directed, table-driven bench for mesh_task_sched
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_task_sched;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mesh_task_sched_if #(.NUM_PE(8), .CNT_W(16)) bus ();

    mesh_task_sched #(.NUM_PE(8), .FLUSH_CYCLES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  pe;
        logic [23:0] dst;
        logic [3:0]  rate;
        logic [3:0]  mode;
        logic [2:0]  rnum;
        logic [2:0]  snum;
        logic        dbg;
    } cfg_vec_t;

    typedef struct {
        logic [7:0]  mask;
        logic [15:0] limit;
        logic [7:0]  send_f;
        logic [7:0]  recv_f;
        int          flag_cycle;   // RUN cycle from which flags are driven (0 = never)
        int          abort_cycle;  // RUN cycle in which abort is driven (0 = never)
        logic [1:0]  exp_status;
        int          exp_cnt;
    } run_vec_t;

    cfg_vec_t cfg_tab[4];
    run_vec_t run_tab[8];
    int       n_runs;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scenario(input int idx, input run_vec_t v);
        int  k;
        bit  seen;
        bus.start         = 1'b1;
        bus.pe_mask       = v.mask;
        bus.timeout_limit = v.limit;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("run%0d_flush", idx), bus.pe_flush, v.mask);
            check($sformatf("run%0d_flush_en", idx), bus.pe_enable, 8'h00);
            step();
        end
        check($sformatf("run%0d_enable", idx), bus.pe_enable, v.mask);
        check($sformatf("run%0d_cnt1", idx), bus.cycle_cnt, 16'd1);
        check($sformatf("run%0d_busy", idx), bus.busy, 1'b1);
        k    = 1;
        seen = 1'b0;
        while (k <= 100 && !seen) begin
            if (v.flag_cycle != 0 && k >= v.flag_cycle) begin
                bus.pe_task_send_finish_flag    = v.send_f;
                bus.pe_task_receive_finish_flag = v.recv_f;
            end else begin
                bus.pe_task_send_finish_flag    = 8'h00;
                bus.pe_task_receive_finish_flag = 8'h00;
            end
            bus.abort = (k == v.abort_cycle);
            step();
            if (bus.done) seen = 1'b1;
            else          k++;
        end
        bus.abort                       = 1'b0;
        bus.pe_task_send_finish_flag    = 8'h00;
        bus.pe_task_receive_finish_flag = 8'h00;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run%0d_no_done: got no done pulse within 100 RUN cycles, required one", idx);
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            step();
            return;
        end
        check($sformatf("run%0d_status", idx), bus.status, v.exp_status);
        check($sformatf("run%0d_cnt", idx), bus.cycle_cnt, v.exp_cnt);
        check($sformatf("run%0d_done_en", idx), bus.pe_enable, 8'h00);
        check($sformatf("run%0d_done_flush", idx), bus.pe_flush, 8'h00);
        check($sformatf("run%0d_done_busy", idx), bus.busy, 1'b0);
        step();
        check($sformatf("run%0d_done_pulse", idx), bus.done, 1'b0);
        check($sformatf("run%0d_status_hold", idx), bus.status, v.exp_status);
    endtask

    initial begin
        bus.cfg_wr                      = 1'b0;
        bus.cfg_pe                      = 3'd0;
        bus.cfg_data                    = '0;
        bus.start                       = 1'b0;
        bus.pe_mask                     = 8'h00;
        bus.abort                       = 1'b0;
        bus.timeout_limit               = 16'd0;
        bus.pe_task_send_finish_flag    = 8'h00;
        bus.pe_task_receive_finish_flag = 8'h00;

        cfg_tab[0] = '{3'd5, 24'h000005, 4'h3, 4'h1, 3'd1, 3'd1, 1'b1};
        cfg_tab[1] = '{3'd0, 24'hABCDEF, 4'hF, 4'h0, 3'd7, 3'd0, 1'b0};
        cfg_tab[2] = '{3'd7, 24'h123456, 4'h8, 4'hA, 3'd2, 3'd5, 1'b1};
        cfg_tab[3] = '{3'd3, 24'hFFFFFF, 4'h0, 4'hF, 3'd0, 3'd7, 1'b0};

        //                mask   limit  send   recv  flag abort st     cnt
        run_tab[0] = '{8'hFF, 16'd0,  8'hFF, 8'hFF, 11, 0, 2'b00, 11}; // normal run
        run_tab[1] = '{8'h0F, 16'd0,  8'h0F, 8'h0F,  6, 0, 2'b00,  6}; // partial mask
        run_tab[2] = '{8'h00, 16'd0,  8'h00, 8'h00,  0, 0, 2'b00,  2}; // empty mask
        run_tab[3] = '{8'hFF, 16'd0,  8'hFF, 8'hFF,  5, 5, 2'b10,  5}; // abort beats completion
        run_tab[4] = '{8'hFF, 16'd7,  8'hFF, 8'hFF,  7, 0, 2'b00,  7}; // completion beats limit
        run_tab[5] = '{8'h3C, 16'd0,  8'hFF, 8'hFF,  1, 0, 2'b00,  2}; // stale first-cycle flags
`ifdef TASK_TIMEOUT_EN
        run_tab[6] = '{8'hFF, 16'd20, 8'hFF, 8'hFB,  1, 0, 2'b01, 20}; // PE2 never finishes
`else
        run_tab[6] = '{8'hFF, 16'd20, 8'hFF, 8'hFB,  1, 30, 2'b10, 30}; // limit ignored
`endif
        n_runs = 7;

        // Reset state
        step();
        step();
        check("rst_enable", bus.pe_enable, 8'h00);
        check("rst_flush", bus.pe_flush, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_status", bus.status, 2'b00);
        check("rst_cnt", bus.cycle_cnt, 16'd0);
        check("rst_dst", bus.pe_dst_seq_wire, 192'd0);
        check("rst_rate", bus.pe_rate_wire, 32'd0);
        rst_n = 1'b1;
        step();

        // Config writes
        foreach (cfg_tab[i]) begin
            bus.cfg_wr   = 1'b1;
            bus.cfg_pe   = cfg_tab[i].pe;
            bus.cfg_data = {cfg_tab[i].dst, cfg_tab[i].rate, cfg_tab[i].mode,
                            cfg_tab[i].rnum, cfg_tab[i].snum, cfg_tab[i].dbg};
            step();
        end
        bus.cfg_wr = 1'b0;
        foreach (cfg_tab[i]) begin
            check($sformatf("cfg%0d_dst", i),  bus.pe_dst_seq_wire[cfg_tab[i].pe*24 +: 24], cfg_tab[i].dst);
            check($sformatf("cfg%0d_rate", i), bus.pe_rate_wire[cfg_tab[i].pe*4 +: 4], cfg_tab[i].rate);
            check($sformatf("cfg%0d_mode", i), bus.pe_mode_wire[cfg_tab[i].pe*4 +: 4], cfg_tab[i].mode);
            check($sformatf("cfg%0d_rnum", i), bus.pe_receive_num_wire[cfg_tab[i].pe*3 +: 3], cfg_tab[i].rnum);
            check($sformatf("cfg%0d_snum", i), bus.pe_send_num_wire[cfg_tab[i].pe*3 +: 3], cfg_tab[i].snum);
            check($sformatf("cfg%0d_dbg", i),  bus.pe_dbg_mode_wire[cfg_tab[i].pe], cfg_tab[i].dbg);
        end
        check("cfg_pe5_dst_abs", bus.pe_dst_seq_wire[143:120], 24'h000005);
        check("cfg_pe5_rate_abs", bus.pe_rate_wire[23:20], 4'h3);
        check("cfg_pe5_dbg_abs", bus.pe_dbg_mode_wire[5], 1'b1);

        // Config write attempted during RUN is ignored
        bus.start   = 1'b1;
        bus.pe_mask = 8'hFF;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.cfg_wr   = 1'b1;
        bus.cfg_pe   = 3'd5;
        bus.cfg_data = {39{1'b1}};
        step();
        bus.cfg_wr = 1'b0;
        step();
        check("runwr_dst", bus.pe_dst_seq_wire[143:120], 24'h000005);
        check("runwr_rate", bus.pe_rate_wire[23:20], 4'h3);
        check("runwr_mode", bus.pe_mode_wire[23:20], 4'h1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("runwr_abort_status", bus.status, 2'b10);
        step();

        for (int r = 0; r < n_runs; r++) run_scenario(r, run_tab[r]);

        // Abort during FLUSH, then start during DONE must be ignored
        bus.start   = 1'b1;
        bus.pe_mask = 8'hAA;
        step();
        bus.start = 1'b0;
        check("fabort_flush", bus.pe_flush, 8'hAA);
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("fabort_done", bus.done, 1'b1);
        check("fabort_status", bus.status, 2'b10);
        check("fabort_cnt", bus.cycle_cnt, 16'd0);
        check("fabort_flush_off", bus.pe_flush, 8'h00);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("done_start_ignored", bus.busy, 1'b0);
        step();
        check("done_start_ignored2", bus.busy, 1'b0);

        // Reset in the middle of RUN
        bus.start   = 1'b1;
        bus.pe_mask = 8'hFF;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        check("mid_pre_enable", bus.pe_enable, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_enable", bus.pe_enable, 8'h00);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_dst", bus.pe_dst_seq_wire, 192'd0);
        check("mid_rst_cnt", bus.cycle_cnt, 16'd0);
        step();
        check("mid_rst_no_done", bus.done, 1'b0);
        rst_n = 1'b1;
        step();
        check("mid_rel_no_done", bus.done, 1'b0);

        // Restart with a simultaneous config write
        bus.cfg_wr   = 1'b1;
        bus.cfg_pe   = 3'd2;
        bus.cfg_data = {24'h0000AA, 4'h6, 4'h2, 3'd3, 3'd4, 1'b1};
        bus.start    = 1'b1;
        bus.pe_mask  = 8'h04;
        step();
        bus.cfg_wr = 1'b0;
        bus.start  = 1'b0;
        check("both_busy", bus.busy, 1'b1);
        check("both_flush", bus.pe_flush, 8'h04);
        check("both_dst", bus.pe_dst_seq_wire[71:48], 24'h0000AA);
        repeat (4) step();
        check("both_enable", bus.pe_enable, 8'h04);
        bus.pe_task_send_finish_flag    = 8'h04;
        bus.pe_task_receive_finish_flag = 8'h04;
        begin
            int n = 0;
            step();
            while (!bus.done && n < 10) begin
                step();
                n++;
            end
        end
        bus.pe_task_send_finish_flag    = 8'h00;
        bus.pe_task_receive_finish_flag = 8'h00;
        check("both_done", bus.done, 1'b1);
        check("both_status", bus.status, 2'b00);
        check("both_cnt", bus.cycle_cnt, 16'd2);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
